test_ctrl: RTL and testbench
============================

// Module: test_ctrl
// PURPOSE
//  Memory-mapped test-completion responder on the CPU data bus. Captures riscv-tests
//  "tohost" exit writes, drains the pipeline, then raises sticky halted plus exit code
//  for the bench. Also provides a cycle counter and a hang watchdog. Sits in top beside data memory.
// PARAMETERS
//  BASE_ADDR     32'h8000_1000  byte address of register block (4 words, offset bits [3:2])
//  TIMEOUT       100000         cycles in RUN before forced halt; 0 disables watchdog
//  DRAIN_CYCLES  4              cycles between exit capture and halted assertion (>=1)
// PORTS
//  clk         in   1   clock, rising edge
//  rst_n       in   1   reset, asynchronous assert, active-low
//  req         in   1   bus request, one cycle per access
//  we          in   1   1=write, 0=read; sampled with req
//  addr        in   32  byte address; block selected when addr[31:4]==BASE_ADDR[31:4]
//  wdata       in   32  write data
//  ack         out  1   one-cycle response pulse, exactly 1 cycle after a selected req
//  rdata       out  32  read data, valid only while ack=1, else 0
//  halted      out  1   sticky; test finished (exit or timeout)
//  pass        out  1   valid when halted: 1 iff exit code==0 and no timeout
//  exit_code   out  31  tohost value >>1; 31'h7FFF_FFFF on timeout
//  con_valid   out  1   console byte strobe (CONSOLE feature only)
//  con_data    out  8   console byte
// BEHAVIOUR
//  Reset: state=RUN; ack, rdata, halted, pass, exit_code, con_valid, con_data, cycle cnt all 0.
//  Registers (offset): 0x0 TOHOST W: bit0=1 -> exit with code wdata[31:1]; bit0=0 ignored.
//   0x0 R: last TOHOST written. 0x4 STATUS R: {29'b0,timeout,halted,draining}.
//   0x8 CYCLE R: low 32 bits of cycles since reset; wraps 2^32-1 -> 0; W ignored.
//   0xC CONSOLE W: see CONFIGURATION. Unused/RO writes ignored; still acked.
//  Handshake: selected req at cycle N -> ack=1, rdata at N+1; back-to-back reqs each acked.
//   Non-selected addresses produce no ack. Reads have no side effects.
//  FSM: RUN -> DRAIN on TOHOST exit write (code latched that cycle) or watchdog expiry.
//   DRAIN counts DRAIN_CYCLES, then -> HALTED: halted=1, pass set. HALTED left only by reset.
//   In DRAIN/HALTED all writes are acked but ignored (first exit wins); reads still served.
//   CYCLE counter keeps running in all states.
//  Watchdog: counts cycles in RUN; at count==TIMEOUT-1 -> DRAIN with timeout=1. Exit write
//   in same cycle as expiry: exit write wins, timeout=0.
//  Reset mid-DRAIN or mid-access: everything returns to reset values, pending ack dropped.
// CONFIGURATION
//  TEST_CTRL_CONSOLE_EN defined: write to 0xC in any state -> con_valid=1 for one cycle,
//   con_data=wdata[7:0], same cycle as ack; STATUS unchanged.
//  Not defined: 0xC writes acked and ignored; con_valid/con_data tied 0.
// STRUCTURE
//  test_ctrl_pkg: register offset localparams, state enum {RUN,DRAIN,HALTED},
//   TIMEOUT_CODE constant 31'h7FFF_FFFF.
//  Sub-module test_ctrl_wdt: watchdog counter (enable, clear, expire pulse), TIMEOUT param.
// TESTING
//  1 Write 0x1 to BASE+0 -> ack next cycle; halted rises 4 cycles later, pass=1, exit_code=0.
//  2 Write 0x7 to BASE+0, then 0x1 in DRAIN -> exit_code=3, pass=0; second write acked, ignored.
//  3 TIMEOUT=50, no writes -> halted at cycle 50+4, STATUS=0x6, exit_code=31'h7FFF_FFFF.
//  4 Read BASE+8 twice 10 cycles apart -> values differ by 10; read 0x9000_0000 -> no ack.
//  5 Write 'A'(0x41) to BASE+0xC -> con_valid pulse with con_data=0x41 iff TEST_CTRL_CONSOLE_EN.
//  6 Assert rst_n=0 mid-DRAIN -> halted, exit_code, counters 0 immediately; runs fresh after release.

Source files
------------

// File: rtl/test_ctrl_pkg.sv
// Shared definitions for the test-completion responder: register offsets,
// controller states and the exit code reported on a watchdog timeout.
package test_ctrl_pkg;

  localparam logic [1:0] OFS_TOHOST  = 2'd0;
  localparam logic [1:0] OFS_STATUS  = 2'd1;
  localparam logic [1:0] OFS_CYCLE   = 2'd2;
  localparam logic [1:0] OFS_CONSOLE = 2'd3;

  localparam logic [30:0] TIMEOUT_CODE = 31'h7FFF_FFFF;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_e;

  function automatic logic [31:0] status_word(input logic timeout, input logic halted,
                                              input logic draining);
    return {29'b0, timeout, halted, draining};
  endfunction

endpackage

// File: rtl/test_ctrl_wdt.sv
// Hang watchdog: down-counter reloaded while cleared, pulses expire when the
// terminal count is reached while enabled. TIMEOUT=0 disables it entirely.
module test_ctrl_wdt #(
  parameter int unsigned TIMEOUT = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic expire
);

  localparam logic [31:0] RELOAD = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;

  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = RELOAD;
    end else if (en && (cnt_q != 32'd0)) begin
      cnt_d = cnt_q - 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= RELOAD;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (TIMEOUT != 0) && en && (cnt_q == 32'd0);

endmodule

// File: rtl/test_ctrl.sv
// Memory-mapped test-completion responder: tohost exit capture, drain, sticky halt,
// cycle counter and watchdog. Console byte port enabled by TEST_CTRL_CONSOLE_EN.
//
//   state  | meaning
//   RUN    | test executing, watchdog counting, exit writes accepted
//   DRAIN  | exit captured, waiting DRAIN_CYCLES before reporting
//   HALTED | result reported; left only by reset
module test_ctrl
  import test_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h8000_1000,
  parameter int unsigned TIMEOUT      = 100000,
  parameter int unsigned DRAIN_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        halted,
  output logic        pass,
  output logic [30:0] exit_code,
  output logic        con_valid,
  output logic [7:0]  con_data
);

  localparam logic [15:0] DRAIN_LOAD = 16'(DRAIN_CYCLES - 1);

  state_e      state_q, state_d;
  logic [15:0] drain_q, drain_d;
  logic [30:0] code_q, code_d;
  logic        timeout_q, timeout_d;
  logic [31:0] tohost_q, tohost_d;
  logic [31:0] cycle_q;
  logic        ack_q;
  logic [31:0] rdata_q, rdata_d;

  logic        sel;
  logic [1:0]  ofs;
  logic        exit_wr;
  logic        wdt_expire;
  logic        unused_addr;

  assign sel         = req && (addr[31:4] == BASE_ADDR[31:4]);
  assign ofs         = addr[3:2];
  assign unused_addr = ^addr[1:0];
  assign exit_wr     = sel && we && (ofs == OFS_TOHOST) && wdata[0] && (state_q == RUN);

  test_ctrl_wdt #(
    .TIMEOUT(TIMEOUT)
  ) u_wdt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state_q == RUN),
    .clr   (state_q != RUN),
    .expire(wdt_expire)
  );

  // An exit write beats a watchdog expiry landing in the same cycle.
  always_comb begin
    state_d   = state_q;
    drain_d   = drain_q;
    code_d    = code_q;
    timeout_d = timeout_q;
    tohost_d  = tohost_q;
    case (state_q)
      RUN: begin
        if (exit_wr) begin
          state_d   = DRAIN;
          drain_d   = DRAIN_LOAD;
          code_d    = wdata[31:1];
          tohost_d  = wdata;
          timeout_d = 1'b0;
        end else if (wdt_expire) begin
          state_d   = DRAIN;
          drain_d   = DRAIN_LOAD;
          code_d    = TIMEOUT_CODE;
          timeout_d = 1'b1;
        end
      end
      DRAIN: begin
        if (drain_q == 16'd0) begin
          state_d = HALTED;
        end else begin
          drain_d = drain_q - 16'd1;
        end
      end
      HALTED: state_d = HALTED;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    rdata_d = 32'd0;
    if (sel && !we) begin
      case (ofs)
        OFS_TOHOST: rdata_d = tohost_q;
        OFS_STATUS: rdata_d = status_word(timeout_q, state_q == HALTED, state_q == DRAIN);
        OFS_CYCLE:  rdata_d = cycle_q;
        default:    rdata_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      drain_q   <= 16'd0;
      code_q    <= 31'd0;
      timeout_q <= 1'b0;
      tohost_q  <= 32'd0;
      cycle_q   <= 32'd0;
      ack_q     <= 1'b0;
      rdata_q   <= 32'd0;
    end else begin
      state_q   <= state_d;
      drain_q   <= drain_d;
      code_q    <= code_d;
      timeout_q <= timeout_d;
      tohost_q  <= tohost_d;
      cycle_q   <= cycle_q + 32'd1;
      ack_q     <= sel;
      rdata_q   <= rdata_d;
    end
  end

  assign ack       = ack_q;
  assign rdata     = rdata_q;
  assign halted    = (state_q == HALTED);
  assign pass      = halted && !timeout_q && (code_q == 31'd0);
  assign exit_code = code_q;

`ifdef TEST_CTRL_CONSOLE_EN
  logic       con_valid_q;
  logic [7:0] con_data_q;
  logic       con_wr;

  assign con_wr = sel && we && (ofs == OFS_CONSOLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      con_valid_q <= 1'b0;
      con_data_q  <= 8'h00;
    end else begin
      con_valid_q <= con_wr;
      if (con_wr) begin
        con_data_q <= wdata[7:0];
      end
    end
  end

  assign con_valid = con_valid_q;
  assign con_data  = con_data_q;
`else
  assign con_valid = 1'b0;
  assign con_data  = 8'h00;
`endif

endmodule

// File: tb/tb_test_ctrl.sv
// Self-checking bench for test_ctrl with a behavioural model of the
// exit/drain/timeout rules, directed scenarios and randomized bus traffic.
module tb_test_ctrl;

  localparam logic [31:0] BASE = 32'h8000_1000;
  localparam int          TO   = 50;
  localparam int          DR   = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic        ack;
  logic [31:0] rdata;
  logic        halted;
  logic        pass;
  logic [30:0] exit_code;
  logic        con_valid;
  logic [7:0]  con_data;

  int checks = 0;
  int errors = 0;

  // model: edges since reset, edge at which DRAIN was entered (-1 = still running)
  int          m_k;
  int          m_end;
  logic [30:0] m_code;
  logic        m_to;
  logic [31:0] m_tohost;
  logic        exp_ack;
  logic [31:0] exp_rdata;
  logic        exp_cv;
  logic [7:0]  exp_cd;

  test_ctrl #(
    .BASE_ADDR   (BASE),
    .TIMEOUT     (TO),
    .DRAIN_CYCLES(DR)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .we       (we),
    .addr     (addr),
    .wdata    (wdata),
    .ack      (ack),
    .rdata    (rdata),
    .halted   (halted),
    .pass     (pass),
    .exit_code(exit_code),
    .con_valid(con_valid),
    .con_data (con_data)
  );

  always #5 clk = ~clk;

  function automatic logic m_halted(input int j);
    return (m_end >= 0) && (j >= m_end + DR);
  endfunction

  function automatic logic m_draining(input int j);
    return (m_end >= 0) && (j < m_end + DR);
  endfunction

  function automatic logic m_pass();
    return m_halted(m_k) && !m_to && (m_code == 31'd0);
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req = 1'b0; we = 1'b0; addr = 32'd0; wdata = 32'd0;
    m_k = 0; m_end = -1; m_code = 31'd0; m_to = 1'b0; m_tohost = 32'd0;
    exp_ack = 1'b0; exp_rdata = 32'd0; exp_cv = 1'b0; exp_cd = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drive one bus cycle at the negedge, advance the model across the posedge,
  // return at the following negedge with exp_* describing the expected outputs.
  task automatic step(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    logic       s;
    logic [1:0] o;
    int         pre;
    req = r; we = w; addr = a; wdata = d;
    s = r && (a[31:4] == BASE[31:4]);
    o = a[3:2];
    pre = m_k;
    exp_ack = s;
    exp_rdata = 32'd0;
    exp_cv = 1'b0;
    if (s && !w) begin
      case (o)
        2'd0: exp_rdata = m_tohost;
        2'd1: exp_rdata = {29'b0, m_to, m_halted(pre), m_draining(pre)};
        2'd2: exp_rdata = 32'(pre);
        default: exp_rdata = 32'd0;
      endcase
    end
`ifdef TEST_CTRL_CONSOLE_EN
    if (s && w && (o == 2'd3)) begin
      exp_cv = 1'b1;
      exp_cd = d[7:0];
    end
`endif
    @(posedge clk);
    m_k = pre + 1;
    if (m_end < 0) begin
      if (s && w && (o == 2'd0) && d[0]) begin
        m_end = m_k; m_code = d[31:1]; m_tohost = d; m_to = 1'b0;
      end else if (m_k == TO) begin
        m_end = m_k; m_code = 31'h7FFF_FFFF; m_to = 1'b1;
      end
    end
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b want 0", ack); end
    checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata got %h want 0", rdata); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b want 0", halted); end
    checks++; if (pass !== 1'b0) begin errors++; $display("FAIL reset_pass got %b want 0", pass); end
    checks++; if (exit_code !== 31'd0) begin errors++; $display("FAIL reset_exit_code got %h want 0", exit_code); end
    checks++; if (con_valid !== 1'b0) begin errors++; $display("FAIL reset_con_valid got %b want 0", con_valid); end
    checks++; if (con_data !== 8'h00) begin errors++; $display("FAIL reset_con_data got %h want 0", con_data); end
    step(1'b1, 1'b0, BASE + 32'h8, 32'd0);
    checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL reset_cycle got %h want 0", rdata); end
  endtask

  task automatic test_exit_pass();
    apply_reset();
    step(1'b1, 1'b1, BASE, 32'h1);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL exit_ack got %b want 1", ack); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL exit_halted_early got %b want 0", halted); end
    for (int i = 2; i <= 5; i++) begin
      step(1'b0, 1'b0, 32'd0, 32'd0);
      checks++;
      if (halted !== (i >= 5)) begin
        errors++; $display("FAIL exit_halted_edge%0d got %b want %b", i, halted, (i >= 5));
      end
    end
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL exit_pass got %b want 1", pass); end
    checks++; if (exit_code !== 31'd0) begin errors++; $display("FAIL exit_code0 got %h want 0", exit_code); end
  endtask

  task automatic test_first_exit_wins();
    apply_reset();
    step(1'b1, 1'b1, BASE, 32'h7);
    step(1'b1, 1'b1, BASE, 32'h1);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL drain_write_ack got %b want 1", ack); end
    step(1'b1, 1'b0, BASE + 32'h4, 32'd0);
    checks++; if (rdata !== 32'h1) begin errors++; $display("FAIL drain_status got %h want 1", rdata); end
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 32'd0, 32'd0);
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL fe_halted got %b want 1", halted); end
    checks++; if (exit_code !== 31'd3) begin errors++; $display("FAIL fe_exit_code got %h want 3", exit_code); end
    checks++; if (pass !== 1'b0) begin errors++; $display("FAIL fe_pass got %b want 0", pass); end
    step(1'b1, 1'b0, BASE, 32'd0);
    checks++; if (rdata !== 32'h7) begin errors++; $display("FAIL fe_tohost got %h want 7", rdata); end
    step(1'b1, 1'b0, BASE + 32'h4, 32'd0);
    checks++; if (rdata !== 32'h2) begin errors++; $display("FAIL fe_status got %h want 2", rdata); end
  endtask

  task automatic test_timeout();
    apply_reset();
    for (int i = 1; i <= TO + DR; i++) begin
      step(1'b0, 1'b0, 32'd0, 32'd0);
      checks++;
      if (halted !== (i >= TO + DR)) begin
        errors++; $display("FAIL to_halted_edge%0d got %b want %b", i, halted, (i >= TO + DR));
      end
    end
    step(1'b1, 1'b0, BASE + 32'h4, 32'd0);
    checks++; if (rdata !== 32'h6) begin errors++; $display("FAIL to_status got %h want 6", rdata); end
    checks++; if (exit_code !== 31'h7FFF_FFFF) begin errors++; $display("FAIL to_exit_code got %h want 7fffffff", exit_code); end
    checks++; if (pass !== 1'b0) begin errors++; $display("FAIL to_pass got %b want 0", pass); end
  endtask

  task automatic test_cycle_and_decode();
    logic [31:0] v1;
    apply_reset();
    for (int i = 0; i < int'($urandom_range(0, 5)); i++) step(1'b0, 1'b0, 32'd0, 32'd0);
    step(1'b1, 1'b0, BASE + 32'h8, 32'd0);
    v1 = rdata;
    checks++; if (rdata !== exp_rdata) begin errors++; $display("FAIL cyc_first got %h want %h", rdata, exp_rdata); end
    for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 32'd0, 32'd0);
    step(1'b1, 1'b0, BASE + 32'h8, 32'd0);
    checks++; if (rdata - v1 !== 32'd10) begin errors++; $display("FAIL cyc_delta got %0d want 10", rdata - v1); end
    step(1'b1, 1'b0, 32'h9000_0000, 32'd0);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL decode_far got %b want 0", ack); end
    step(1'b1, 1'b1, BASE + 32'h10, 32'h1);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL decode_adjacent got %b want 0", ack); end
    checks++; if (halted !== 1'b0 || m_end !== -1) begin errors++; $display("FAIL decode_side_effect halted %b want 0", halted); end
  endtask

  task automatic test_console();
    logic       want_v;
    logic [7:0] want_d;
`ifdef TEST_CTRL_CONSOLE_EN
    want_v = 1'b1; want_d = 8'h41;
`else
    want_v = 1'b0; want_d = 8'h00;
`endif
    apply_reset();
    step(1'b1, 1'b1, BASE + 32'hC, 32'h41);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL con_ack got %b want 1", ack); end
    checks++; if (con_valid !== want_v) begin errors++; $display("FAIL con_valid got %b want %b", con_valid, want_v); end
    checks++; if (con_data !== want_d) begin errors++; $display("FAIL con_data got %h want %h", con_data, want_d); end
    step(1'b1, 1'b0, BASE + 32'h4, 32'd0);
    checks++; if (con_valid !== 1'b0) begin errors++; $display("FAIL con_pulse_len got %b want 0", con_valid); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL con_status got %h want 0", rdata); end
  endtask

  task automatic test_reset_mid_drain();
    apply_reset();
    step(1'b1, 1'b1, BASE, 32'h5);
    step(1'b1, 1'b0, BASE + 32'h4, 32'd0);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL mid_ack_pending got %b want 1", ack); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL mid_ack got %b want 0", ack); end
    checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL mid_rdata got %h want 0", rdata); end
    checks++; if (exit_code !== 31'd0) begin errors++; $display("FAIL mid_exit_code got %h want 0", exit_code); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL mid_halted got %b want 0", halted); end
    apply_reset();
    step(1'b1, 1'b0, BASE + 32'h8, 32'd0);
    checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL mid_cycle got %h want 0", rdata); end
    step(1'b1, 1'b0, BASE + 32'h4, 32'd0);
    checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL mid_status got %h want 0", rdata); end
    step(1'b1, 1'b1, BASE, 32'h1);
    for (int i = 0; i < DR; i++) step(1'b0, 1'b0, 32'd0, 32'd0);
    checks++; if (halted !== 1'b1 || pass !== 1'b1) begin errors++; $display("FAIL mid_rerun got halted %b pass %b want 1 1", halted, pass); end
  endtask

  task automatic test_random();
    logic        r, w;
    logic [31:0] a, d;
    for (int round = 0; round < 8; round++) begin
      apply_reset();
      for (int n = 0; n < 70; n++) begin
        r = ($urandom_range(0, 3) != 0);
        w = $urandom_range(0, 1) == 1;
        if ($urandom_range(0, 7) == 0) begin
          a = $urandom;
          a[31:28] = 4'h9;
        end else begin
          a = BASE + 32'($urandom_range(0, 3) * 4);
        end
        d = $urandom;
        if ($urandom_range(0, 9) != 0) d[0] = 1'b0;
        if ($urandom_range(0, 19) == 0) d = 32'h1;
        step(r, w, a, d);
        checks++; if (ack !== exp_ack) begin errors++; $display("FAIL rnd_ack r%0d n%0d got %b want %b", round, n, ack, exp_ack); end
        checks++; if (rdata !== exp_rdata) begin errors++; $display("FAIL rnd_rdata r%0d n%0d got %h want %h", round, n, rdata, exp_rdata); end
        checks++; if (halted !== m_halted(m_k)) begin errors++; $display("FAIL rnd_halted r%0d n%0d got %b want %b", round, n, halted, m_halted(m_k)); end
        checks++; if (exit_code !== m_code) begin errors++; $display("FAIL rnd_exit_code r%0d n%0d got %h want %h", round, n, exit_code, m_code); end
        checks++; if (con_valid !== exp_cv) begin errors++; $display("FAIL rnd_con_valid r%0d n%0d got %b want %b", round, n, con_valid, exp_cv); end
        if (m_halted(m_k)) begin
          checks++; if (pass !== m_pass()) begin errors++; $display("FAIL rnd_pass r%0d n%0d got %b want %b", round, n, pass, m_pass()); end
        end
        if (exp_cv) begin
          checks++; if (con_data !== exp_cd) begin errors++; $display("FAIL rnd_con_data r%0d n%0d got %h want %h", round, n, con_data, exp_cd); end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_exit_pass();
    test_first_exit_wins();
    test_timeout();
    test_cycle_and_decode();
    test_console();
    test_reset_mid_drain();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
